branch_ctrl: RTL and testbench

- Control-flow front end that drives the program counter's `jump_en`, `branch_en` and `destination` inputs. This is the issuing side of the PC redirect interface.
- Evaluates decoded jump and conditional-branch instructions against registered ALU flags.
- Resolves jump targets through a writable 32-entry target lookup table.
- Squashes the one wrong-path instruction in flight after every redirect, because the instruction memory has a registered read.

---
 rtl/branch_ctrl_pkg.sv | 27 ++
 rtl/branch_ctrl_if.sv | 27 ++
 rtl/branch_ctrl_jump_lut.sv | 28 ++
 rtl/branch_ctrl.sv | 80 ++++++++
 tb/tb_branch_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared types, default widths and branch condition decode
package branch_ctrl_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_IDX_W = 5;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    COND_Z  = 2'd0,
    COND_NZ = 2'd1,
    COND_C  = 2'd2,
    COND_NC = 2'd3
  } cond_t;

  function automatic logic cond_eval(input cond_t c, input logic z, input logic cy);
    return (c == COND_Z)  ? z :
           (c == COND_NZ) ? ~z :
           (c == COND_C)  ? cy : ~cy;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: PC redirect interface; master issues redirects, PC reports halt
interface branch_ctrl_if
  import branch_ctrl_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
);

  logic            jump_en;
  logic            branch_en;
  logic [PC_W-1:0] destination;
  logic            halt;

  modport master (
    output jump_en,
    output branch_en,
    output destination,
    input  halt
  );

  modport slave (
    input  jump_en,
    input  branch_en,
    input  destination,
    output halt
  );

endinterface

// File: rtl/branch_ctrl_jump_lut.sv
// jump_lut: writable jump-target table, synchronous write, combinational read
module jump_lut #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5
) (
  input  logic             CLK,
  input  logic             init_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] mem [2**IDX_W];

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read sees the pre-write contents during a same-cycle write
  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves jumps/conditional branches into PC redirects and
// squashes the single wrong-path instruction fetched behind each redirect.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               init_n,
  input  logic               instr_valid,
  input  logic               is_jump,
  input  logic               is_branch,
  input  logic [1:0]         cond,
  input  logic [IDX_W-1:0]   target_idx,
  input  logic               flag_we,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               lut_we,
  input  logic [IDX_W-1:0]   lut_waddr,
  input  logic [PC_W-1:0]    lut_wdata,
  branch_ctrl_if.master      pc,
  output logic               squash,
  output logic [CNT_W-1:0]   redirect_cnt,
  output logic               halted
);

  state_t          state;
  logic            z_flag;
  logic            c_flag;
  logic            active;
  logic            cond_true;
  logic            redirect;
  logic [PC_W-1:0] lut_rdata;

  jump_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_lut (
    .CLK   (CLK),
    .init_n(init_n),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (target_idx),
    .rdata (lut_rdata)
  );

  // init_n gates the Mealy outputs so nothing leaks out while reset is held
  always_comb begin
    active         = init_n && (state == RUN) && instr_valid;
    cond_true      = cond_eval(cond_t'(cond), z_flag, c_flag);
    pc.jump_en     = active && is_jump;
    pc.branch_en   = active && is_branch && !is_jump && cond_true;
    pc.destination = pc.jump_en ? lut_rdata : '0;
    redirect       = pc.jump_en || pc.branch_en;
    squash         = (state == SQUASH);
    halted         = (state == HALTED);
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state        <= RUN;
      z_flag       <= 1'b0;
      c_flag       <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state <= (pc.halt || state == HALTED) ? HALTED :
               (state == SQUASH)            ? RUN    :
               redirect                     ? SQUASH : RUN;
      if (state == RUN && flag_we) begin
        z_flag <= alu_zero;
        c_flag <= alu_carry;
      end
      if (redirect && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed vectors with hand-computed expectations for branch_ctrl
module tb_branch_ctrl;

  logic       CLK = 1'b0;
  logic       init_n;
  logic       instr_valid, is_jump, is_branch, flag_we, alu_zero, alu_carry, lut_we;
  logic [1:0] cond;
  logic [4:0] target_idx, lut_waddr;
  logic [9:0] lut_wdata;
  logic       squash, halted;
  logic [7:0] redirect_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  branch_ctrl_if #(.PC_W(10)) pc ();

  branch_ctrl dut (
    .CLK         (CLK),
    .init_n      (init_n),
    .instr_valid (instr_valid),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .cond        (cond),
    .target_idx  (target_idx),
    .flag_we     (flag_we),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .pc          (pc),
    .squash      (squash),
    .redirect_cnt(redirect_cnt),
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    instr_valid = 0; is_jump = 0; is_branch = 0; flag_we = 0; lut_we = 0;
  endtask

  initial begin
    int jumps, squashes, alt_err;
    logic prev_j;
    init_n = 0; pc.halt = 0; idle();
    cond = 0; target_idx = 0; alu_zero = 0; alu_carry = 0; lut_waddr = 0; lut_wdata = 0;
    instr_valid = 1; is_jump = 1;
    #3;
    check("rst_jump_en", pc.jump_en, 0);
    check("rst_dest", pc.destination, 0);
    check("rst_squash", squash, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", redirect_cnt, 0);
    idle();
    @(negedge CLK) init_n = 1;
    // jump through LUT[3]
    lut_we = 1; lut_waddr = 3; lut_wdata = 10'd200;
    tick();
    lut_we = 0; instr_valid = 1; is_jump = 1; target_idx = 3;
    #1;
    check("jmp_en", pc.jump_en, 1);
    check("jmp_dest", pc.destination, 200);
    tick();
    check("jmp_squash", squash, 1);
    check("jmp_sq_en", pc.jump_en, 0);
    check("jmp_sq_dest", pc.destination, 0);
    idle();
    tick();
    check("jmp_run", squash, 0);
    check("jmp_cnt", redirect_cnt, 1);
    // flags and branch conditions
    flag_we = 1; alu_zero = 1; alu_carry = 0;
    tick();
    flag_we = 0; instr_valid = 1; is_branch = 1; cond = 0;
    #1 check("br_z", pc.branch_en, 1);
    cond = 1; #1 check("br_nz", pc.branch_en, 0);
    cond = 2; #1 check("br_c", pc.branch_en, 0);
    cond = 3; #1 check("br_nc", pc.branch_en, 1);
    cond = 0; flag_we = 1; alu_zero = 0;
    #1 check("br_old_z", pc.branch_en, 1);
    tick();
    check("br_squash", squash, 1);
    instr_valid = 0; is_branch = 0; flag_we = 1; alu_zero = 1;
    tick();
    flag_we = 0; instr_valid = 1; is_branch = 1; cond = 0;
    #1 check("br_new_z", pc.branch_en, 0);
    cond = 1; #1 check("br_new_nz", pc.branch_en, 1);
    check("br_cnt", redirect_cnt, 2);
    // jump and branch together: jump wins
    is_jump = 1; target_idx = 3;
    #1;
    check("both_jump", pc.jump_en, 1);
    check("both_branch", pc.branch_en, 0);
    check("both_dest", pc.destination, 200);
    tick();
    idle();
    check("both_cnt", redirect_cnt, 3);
    tick();
    // back-to-back jumps until saturation
    instr_valid = 1; is_jump = 1;
    jumps = 0; squashes = 0; alt_err = 0; prev_j = 0;
    for (int i = 0; i < 600; i++) begin
      #1;
      jumps += int'(pc.jump_en);
      squashes += int'(squash);
      if (squash !== prev_j) alt_err++;
      prev_j = pc.jump_en;
      tick();
    end
    idle();
    check("sat_jumps", jumps, 300);
    check("sat_squashes", squashes, 300);
    check("sat_alternate", alt_err, 0);
    check("sat_cnt", redirect_cnt, 255);
    // halt with a jump pending
    instr_valid = 1; is_jump = 1; pc.halt = 1;
    #1 check("halt_pend_jmp", pc.jump_en, 1);
    tick();
    pc.halt = 0;
    check("halt_halted", halted, 1);
    check("halt_jmp", pc.jump_en, 0);
    check("halt_squash", squash, 0);
    is_jump = 0; is_branch = 1; cond = 1;
    lut_we = 1; lut_waddr = 5; lut_wdata = 10'd77;
    #1 check("halt_br", pc.branch_en, 0);
    tick();
    lut_we = 0;
    tick();
    check("halt_stay", halted, 1);
    check("halt_lut", dut.u_lut.mem[5], 77);
    idle();
    // leave HALTED, then reset asynchronously mid-SQUASH
    init_n = 0;
    #1 check("unhalt", halted, 0);
    @(negedge CLK) init_n = 1;
    flag_we = 1; alu_zero = 1; alu_carry = 1; lut_we = 1; lut_waddr = 3; lut_wdata = 10'd200;
    tick();
    idle();
    instr_valid = 1; is_jump = 1; target_idx = 3;
    #1 check("pre_rst_dest", pc.destination, 200);
    tick();
    idle();
    check("pre_rst_squash", squash, 1);
    check("pre_rst_cnt", redirect_cnt, 1);
    #2 init_n = 0;
    #1;
    check("arst_squash", squash, 0);
    check("arst_halted", halted, 0);
    check("arst_cnt", redirect_cnt, 0);
    @(negedge CLK) init_n = 1;
    instr_valid = 1; is_branch = 1; cond = 0;
    #1 check("arst_z", pc.branch_en, 0);
    cond = 3; #1 check("arst_c", pc.branch_en, 1);
    is_branch = 0; is_jump = 1; target_idx = 3;
    #1 check("arst_lut3", pc.destination, 0);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
